shift_arith_seq_unit: RTL and testbench

//  Parametrised, registered shift/arithmetic execution unit; next generation of the 4-bit combinational

---
 rtl/shift_arith_seq_unit_pkg.sv | 23 ++
 rtl/shift_arith_seq_unit_if.sv | 42 ++++
 rtl/shift_arith_seq_unit_mult.sv | 54 +++++
 rtl/shift_arith_seq_unit.sv | 178 +++++++++++++++++
 tb/tb_shift_arith_seq_unit.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_arith_seq_unit_pkg.sv
// Shared types for the shift/arithmetic sequential unit: opcodes and FSM states.
// Optional overflow output is enabled with the SHIFT_ARITH_OVF_EN macro.
package shift_arith_pkg;

    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_ASR = 3'd1,
        OP_LSR = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_MUL = 3'd5,
        OP_CAT = 3'd6,
        OP_ILL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/shift_arith_seq_unit_if.sv
// Request/result bus of the shift/arithmetic unit.
// The ovf signal exists only when SHIFT_ARITH_OVF_EN is defined.
interface shift_arith_seq_unit_if #(
    parameter int WIDTH = 4
) ();
    localparam int SHW = $clog2(WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [SHW-1:0]       shamt;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 carry;
    logic                 op_err;
    logic                 busy;
`ifdef SHIFT_ARITH_OVF_EN
    logic                 ovf;
`endif

    // Requester / result consumer side
    modport master (
        output in_valid, op, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, carry, op_err, busy
`ifdef SHIFT_ARITH_OVF_EN
        , input ovf
`endif
    );

    // Execution unit side
    modport slave (
        input  in_valid, op, a, b, shamt, out_ready,
        output in_ready, out_valid, result, carry, op_err, busy
`ifdef SHIFT_ARITH_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/shift_arith_seq_unit_mult.sv
// Sequential shift-add multiplier: loads operands on start, then runs exactly
// WIDTH iterations regardless of operand values; done pulses with the final product.
module seq_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      cnt_reg;
    logic               done_reg;

    // One iteration per cycle: conditionally accumulate, then shift operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                acc_reg    <= '0;
                mcand_reg  <= {{WIDTH{1'b0}}, a};
                mplier_reg <= b;
                cnt_reg    <= CW'(WIDTH);
            end else if (cnt_reg != '0) begin
                if (mplier_reg[0]) begin
                    acc_reg <= acc_reg + mcand_reg;
                end
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done    = done_reg;
    assign product = acc_reg;

endmodule

// File: rtl/shift_arith_seq_unit.sv
// Registered shift/add/multiply execution unit, one transaction in flight.
// Define SHIFT_ARITH_OVF_EN to add the signed-overflow output (ovf).
module shift_arith_seq_unit
    import shift_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    shift_arith_seq_unit_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    state_e               state_reg;
    op_e                  op_reg;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [SHW-1:0]       shamt_reg;
    logic                 in_ready_reg;
    logic                 out_valid_reg;
    logic                 busy_reg;
    logic [2*WIDTH-1:0]   result_reg;
    logic                 carry_reg;
    logic                 op_err_reg;

    logic                 accept;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    logic [WIDTH-1:0]     lsl_val;
    logic [WIDTH-1:0]     asr_val;
    logic [WIDTH-1:0]     lsr_val;
    logic [WIDTH:0]       sum_val;
    logic [WIDTH:0]       diff_val;
    logic [2*WIDTH-1:0]   result_next;
    logic                 carry_next;
    logic                 op_err_next;

    // in_ready is a pure register, so accept never loops back into it
    assign accept    = bus.in_valid && in_ready_reg;
    assign mul_start = accept && (op_e'(bus.op) == OP_MUL);

    seq_shift_add_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle shift/add/cat datapath on the captured operands
    always_comb begin
        lsl_val     = a_reg << shamt_reg;
        asr_val     = $signed(a_reg) >>> shamt_reg;
        lsr_val     = a_reg >> shamt_reg;
        sum_val     = {1'b0, a_reg} + {1'b0, b_reg};
        diff_val    = {1'b0, a_reg} - {1'b0, b_reg};
        result_next = '0;
        carry_next  = 1'b0;
        op_err_next = 1'b0;
        case (op_reg)
            OP_LSL: result_next = {{WIDTH{1'b0}}, lsl_val};
            OP_ASR: result_next = {{WIDTH{asr_val[WIDTH-1]}}, asr_val};
            OP_LSR: result_next = {{WIDTH{1'b0}}, lsr_val};
            OP_ADD: begin
                result_next = {{WIDTH{1'b0}}, sum_val[WIDTH-1:0]};
                carry_next  = sum_val[WIDTH];
            end
            OP_SUB: begin
                result_next = {{WIDTH{1'b0}}, diff_val[WIDTH-1:0]};
                carry_next  = ~diff_val[WIDTH];
            end
            OP_MUL: result_next = '0;
            OP_CAT: result_next = {a_reg, a_reg[WIDTH-2:0], 1'b0};
            default: op_err_next = 1'b1;
        endcase
    end

`ifdef SHIFT_ARITH_OVF_EN
    logic                   ovf_reg;
    logic                   ovf_next;
    logic signed [2*WIDTH:0] lsl_wide;

    // Overflow: LSL is exact only if the wide signed shift equals the sign-extended truncated result
    always_comb begin
        lsl_wide = $signed({{(WIDTH+1){a_reg[WIDTH-1]}}, a_reg}) <<< shamt_reg;
        ovf_next = 1'b0;
        case (op_reg)
            OP_LSL: ovf_next = (lsl_wide != {{(WIDTH+1){lsl_val[WIDTH-1]}}, lsl_val});
            OP_ADD: ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                               (sum_val[WIDTH-1] != a_reg[WIDTH-1]);
            OP_SUB: ovf_next = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                               (diff_val[WIDTH-1] != a_reg[WIDTH-1]);
            default: ovf_next = 1'b0;
        endcase
    end

    // Overflow flag is loaded and held alongside the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == S_EXEC) begin
            ovf_reg <= ovf_next;
        end else if (state_reg == S_MUL && mul_done) begin
            ovf_reg <= 1'b0;
        end
    end

    assign bus.ovf = ovf_reg;
`endif

    // Control FSM with operand capture and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            op_reg        <= OP_LSL;
            a_reg         <= '0;
            b_reg         <= '0;
            shamt_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            op_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_reg       <= op_e'(bus.op);
                        a_reg        <= bus.a;
                        b_reg        <= bus.b;
                        shamt_reg    <= bus.shamt;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= (op_e'(bus.op) == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_reg    <= result_next;
                    carry_reg     <= carry_next;
                    op_err_reg    <= op_err_next;
                    out_valid_reg <= 1'b1;
                    state_reg     <= S_DONE;
                end
                S_MUL: begin
                    if (mul_done) begin
                        result_reg    <= mul_product;
                        carry_reg     <= 1'b0;
                        op_err_reg    <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.result    = result_reg;
    assign bus.carry     = carry_reg;
    assign bus.op_err    = op_err_reg;

endmodule

// File: tb/tb_shift_arith_seq_unit.sv
// Bench for shift_arith_seq_unit: directed vector table, handshake corner cases
// and randomized operations at WIDTH=4 and WIDTH=8 against an arithmetic model.
// Overflow checks are included when SHIFT_ARITH_OVF_EN is defined.
module tb_shift_arith_seq_unit;
    localparam int W    = 4;
    localparam int SHW  = $clog2(W);
    localparam int W8   = 8;
    localparam int SHW8 = $clog2(W8);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_arith_seq_unit_if #(.WIDTH(W))  bus ();
    shift_arith_seq_unit_if #(.WIDTH(W8)) bus8 ();

    shift_arith_seq_unit #(.WIDTH(W))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    shift_arith_seq_unit #(.WIDTH(W8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    typedef struct {
        longint res;
        bit     carry;
        bit     err;
        bit     ovf;
    } model_t;

    // Reference: value-level arithmetic on integers
    function automatic model_t model(input int w, input int op, input longint a,
                                     input longint b, input int sh);
        model_t r;
        longint md   = longint'(1) << w;
        longint half = md / 2;
        longint sa   = (a >= half) ? a - md : a;
        longint sb   = (b >= half) ? b - md : b;
        longint t;
        r = '{0, 0, 0, 0};
        case (op)
            0: begin
                t     = sa * (longint'(1) << sh);
                r.res = (a * (longint'(1) << sh)) % md;
                r.ovf = (t < -half) || (t > half - 1);
            end
            1: begin
                t     = sa >>> sh;
                r.res = (t < 0) ? t + md * md : t;
            end
            2: r.res = a / (longint'(1) << sh);
            3: begin
                r.res   = (a + b) % md;
                r.carry = (a + b) >= md;
                r.ovf   = (sa + sb < -half) || (sa + sb > half - 1);
            end
            4: begin
                r.res   = (a - b + md) % md;
                r.carry = (a >= b);
                r.ovf   = (sa - sb < -half) || (sa - sb > half - 1);
            end
            5: r.res = a * b;
            6: r.res = a * md + (2 * a) % md;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Present a request at a negedge and let it be accepted on the next posedge
    task automatic issue(input int op, input int a, input int b, input int sh);
        int guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("issue_ready", longint'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.op       = op[2:0];
        bus.a        = a[W-1:0];
        bus.b        = b[W-1:0];
        bus.shamt    = sh[SHW-1:0];
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.op       = 3'($urandom);
        bus.shamt    = SHW'($urandom);
    endtask

    // Count cycles from accept until out_valid, noting any in_ready while busy
    task automatic wait_out(output int lat, output int rdy_seen);
        lat      = 1;
        rdy_seen = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_seen++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic complete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_check(input string name, input int op, input int a, input int b,
                             input int sh, input longint e_res, input bit e_carry,
                             input bit e_err, input bit e_ovf, input int e_lat);
        int lat;
        int rdy_seen;
        issue(op, a, b, sh);
        wait_out(lat, rdy_seen);
        $display("txn %s op=%0d a=%0h b=%0h sh=%0d -> result=%0h carry=%0b err=%0b lat=%0d",
                 name, op, a, b, sh, bus.result, bus.carry, bus.op_err, lat);
        chk({name, "_lat"},    lat, e_lat);
        chk({name, "_res"},    longint'(bus.result), e_res);
        chk({name, "_carry"},  longint'(bus.carry), longint'(e_carry));
        chk({name, "_err"},    longint'(bus.op_err), longint'(e_err));
        chk({name, "_nordy"},  rdy_seen, 0);
`ifdef SHIFT_ARITH_OVF_EN
        chk({name, "_ovf"},    longint'(bus.ovf), longint'(e_ovf));
`endif
        complete();
    endtask

    task automatic run8(input int op, input int a, input int b, input int sh);
        model_t m;
        int lat = 1;
        m = model(W8, op, a, b, sh);
        chk("w8_ready", longint'(bus8.in_ready), 1);
        bus8.in_valid = 1'b1;
        bus8.op       = op[2:0];
        bus8.a        = a[W8-1:0];
        bus8.b        = b[W8-1:0];
        bus8.shamt    = sh[SHW8-1:0];
        @(negedge clk);
        bus8.in_valid = 1'b0;
        while (!bus8.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        $display("txn w8 op=%0d a=%0h b=%0h sh=%0d -> result=%0h lat=%0d",
                 op, a, b, sh, bus8.result, lat);
        chk("w8_lat",   lat, (op == 5) ? W8 + 2 : 2);
        chk("w8_res",   longint'(bus8.result), m.res);
        chk("w8_carry", longint'(bus8.carry), longint'(m.carry));
        chk("w8_err",   longint'(bus8.op_err), longint'(m.err));
`ifdef SHIFT_ARITH_OVF_EN
        chk("w8_ovf",   longint'(bus8.ovf), longint'(m.ovf));
`endif
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
    endtask

    typedef struct {
        int     op;
        int     a;
        int     b;
        int     sh;
        longint res;
        bit     carry;
        bit     err;
        bit     ovf;
        int     lat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int rdy_seen;
        model_t m;

        vecs[0]  = '{0, 4'hB, 0, 1, 64'h06, 0, 0, 1, 2};
        vecs[1]  = '{1, 4'hB, 0, 1, 64'hFD, 0, 0, 0, 2};
        vecs[2]  = '{2, 4'hB, 0, 1, 64'h05, 0, 0, 0, 2};
        vecs[3]  = '{3, 9, 8, 0, 64'h01, 1, 0, 1, 2};
        vecs[4]  = '{4, 3, 5, 0, 64'h0E, 0, 0, 0, 2};
        vecs[5]  = '{3, 7, 1, 0, 64'h08, 0, 0, 1, 2};
        vecs[6]  = '{5, 15, 15, 0, 64'hE1, 0, 0, 0, 6};
        vecs[7]  = '{5, 0, 9, 0, 64'h00, 0, 0, 0, 6};
        vecs[8]  = '{6, 4'hB, 0, 0, 64'hB6, 0, 0, 0, 2};
        vecs[9]  = '{7, 4'hB, 3, 2, 64'h00, 0, 1, 0, 2};
        vecs[10] = '{0, 1, 0, 3, 64'h08, 0, 0, 1, 2};
        vecs[11] = '{1, 8, 0, 3, 64'hFF, 0, 0, 0, 2};
        vecs[12] = '{4, 5, 3, 0, 64'h02, 1, 0, 0, 2};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0;
        bus.a = '0; bus.b = '0; bus.shamt = '0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.op = '0;
        bus8.a = '0; bus8.b = '0; bus8.shamt = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  longint'(bus.in_ready), 1);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_result",    longint'(bus.result), 0);
        chk("rst_busy",      longint'(bus.busy), 0);
        chk("rst_carry",     longint'(bus.carry), 0);
        chk("rst_op_err",    longint'(bus.op_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
                      vecs[i].res, vecs[i].carry, vecs[i].err, vecs[i].ovf, vecs[i].lat);
        end

        // Backpressure: result held, in_ready low, stray requests ignored
        issue(3, 9, 8, 0);
        wait_out(lat, rdy_seen);
        chk("bp_lat", lat, 2);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.op       = 3'd5;
            bus.a        = W'($urandom);
            chk("bp_result",   longint'(bus.result), 8'h01);
            chk("bp_carry",    longint'(bus.carry), 1);
            chk("bp_out_valid", longint'(bus.out_valid), 1);
            chk("bp_in_ready", longint'(bus.in_ready), 0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        $display("txn backpressure held result=%0h for 5 cycles", bus.result);
        complete();
        chk("bp_idle_ready", longint'(bus.in_ready), 1);
        run_check("post_bp", 2, 4'hC, 0, 2, 64'h03, 0, 0, 0, 2);

        // Reset in the middle of a multiply
        issue(5, 15, 15, 0);
        repeat (2) @(negedge clk);
        chk("mid_busy", longint'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        $display("txn reset mid-MUL in_ready=%0b out_valid=%0b busy=%0b", bus.in_ready, bus.out_valid, bus.busy);
        chk("mid_rst_in_ready",  longint'(bus.in_ready), 1);
        chk("mid_rst_out_valid", longint'(bus.out_valid), 0);
        chk("mid_rst_busy",      longint'(bus.busy), 0);
        chk("mid_rst_result",    longint'(bus.result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_no_stray_valid", longint'(bus.out_valid), 0);
        run_check("after_rst_cat", 6, 4'hB, 0, 0, 64'hB6, 0, 0, 0, 2);
        run_check("after_rst_ill", 7, 4'h5, 4'h5, 1, 64'h00, 0, 1, 0, 2);
        run_check("after_rst_mul", 5, 3, 5, 0, 64'h0F, 0, 0, 0, 6);

        // Randomized operations at WIDTH=4
        for (int i = 0; i < 150; i++) begin
            int op = $urandom_range(0, 7);
            int a  = $urandom_range(0, (1 << W) - 1);
            int b  = $urandom_range(0, (1 << W) - 1);
            int sh = $urandom_range(0, (1 << SHW) - 1);
            m = model(W, op, a, b, sh);
            run_check("rnd4", op, a, b, sh, m.res, m.carry, m.err, m.ovf, (op == 5) ? W + 2 : 2);
        end

        // WIDTH=8 regression, directed then randomized
        run8(5, 255, 255, 0);
        run8(1, 8'h80, 0, 7);
        run8(3, 8'hFF, 1, 0);
        for (int i = 0; i < 60; i++) begin
            run8($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, (1 << SHW8) - 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
